// File: rtl/fb_line_reader.sv
// fb_line_reader: fetches one RGB565 framebuffer line from DDRAM in fixed
// bursts and streams it as 16-bit pixels over a valid/ready interface.
module fb_line_reader #(
    parameter logic [31:0] FB_BASE    = 32'h2000_0000,
    parameter int          STRIDE     = 4096,
    parameter int          WIDTH      = 1920,
    parameter int          BURST      = 32,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [10:0] line,
    output logic        busy,
    output logic        done,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    output logic        ddram_rd,
    input  logic [63:0] ddram_dout,
    input  logic        ddram_dout_ready,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last
);

    localparam int                PTR_W       = $clog2(FIFO_DEPTH);
    localparam int                CNT_W       = PTR_W + 1;
    localparam logic [15:0]       LINE_WORDS  = 16'(WIDTH / 4);
    localparam logic [15:0]       BURST_WORDS = 16'(BURST);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST - 1);
    localparam logic [CNT_W-1:0]  ISSUE_LIMIT = CNT_W'(FIFO_DEPTH - BURST);
    localparam logic [10:0]       LAST_PIX    = 11'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t            state, state_next;
    logic [10:0]       line_q;
    logic [15:0]       word_cnt;
    logic [7:0]        beat_cnt;
    logic              beat_valid;
    logic [63:0]       beat_data;
    logic [63:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count, fifo_used;
    logic              fifo_empty, space_ok;
    logic [63:0]       hold_word;
    logic [1:0]        pix_idx;
    logic [10:0]       pix_cnt;
    logic              pix_fire, last_fire, pop;
    logic              cmd_accept, beat_in, burst_end;
    logic [28:0]       word_addr;

    // A beat registered but not yet written still occupies a FIFO slot.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_used  = fifo_count + CNT_W'(beat_valid);
    assign space_ok   = (fifo_used <= ISSUE_LIMIT);

    assign cmd_accept = (state == S_ISSUE) && ddram_rd && !ddram_busy;
    assign beat_in    = (state == S_WAIT) && ddram_dout_ready;
    assign burst_end  = beat_in && (beat_cnt == LAST_BEAT);

    assign pix_fire   = pix_valid && pix_ready;
    assign last_fire  = pix_fire && pix_last;
    // Refill the pixel holder when empty or when its 4th pixel leaves.
    assign pop        = !fifo_empty && (!pix_valid || (pix_fire && pix_idx == 2'd3));

    assign busy           = (state != S_IDLE);
    assign ddram_burstcnt = 8'(BURST);
    assign pix_last       = pix_valid && (pix_cnt == LAST_PIX);

    // Byte address of the next burst, reduced to a 64-bit word address.
    assign word_addr = 29'((FB_BASE + 32'(line_q) * 32'(STRIDE) + (32'(word_cnt) << 3)) >> 3);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = S_ISSUE;
            S_ISSUE: if (cmd_accept) state_next = S_WAIT;
            S_WAIT:  if (burst_end) state_next = (word_cnt < LINE_WORDS) ? S_ISSUE : S_DRAIN;
            S_DRAIN: if (fifo_empty && last_fire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command channel, burst bookkeeping and the done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_q     <= '0;
            word_cnt   <= '0;
            beat_cnt   <= '0;
            ddram_rd   <= 1'b0;
            ddram_addr <= '0;
            done       <= 1'b0;
            beat_valid <= 1'b0;
        end else begin
            done       <= (state == S_DRAIN) && (state_next == S_IDLE);
            beat_valid <= beat_in;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        line_q   <= line;
                        word_cnt <= '0;
                        beat_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    if (cmd_accept) begin
                        ddram_rd <= 1'b0;
                        word_cnt <= word_cnt + BURST_WORDS;
                    end else if (!ddram_rd && space_ok) begin
                        ddram_rd   <= 1'b1;
                        ddram_addr <= word_addr;
                    end
                end
                S_WAIT: begin
                    if (beat_in) beat_cnt <= burst_end ? 8'd0 : beat_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Beat capture and FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: data-only storage carries no reset; validity is tracked by
        // beat_valid and the FIFO pointers, which are reset.
        beat_data <= ddram_dout;
        if (beat_valid) fifo_mem[wr_ptr] <= beat_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (beat_valid) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(beat_valid) - CNT_W'(pop);
        end
    end

    // Unpacker: one 64-bit word becomes four pixels, low half-word first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_word <= '0;
            pix_valid <= 1'b0;
            pix_idx   <= '0;
            pix_cnt   <= '0;
        end else begin
            if (pix_fire) begin
                pix_idx <= pix_idx + 2'd1;
                pix_cnt <= (pix_cnt == LAST_PIX) ? 11'd0 : pix_cnt + 11'd1;
                if (pix_idx == 2'd3) pix_valid <= 1'b0;
            end
            if (pop) begin
                hold_word <= fifo_mem[rd_ptr];
                pix_valid <= 1'b1;
                pix_idx   <= 2'd0;
            end
        end
    end

    // Pixel select from the held word.
    always_comb begin
        pix_data = hold_word[15:0];
        case (pix_idx)
            2'd1:    pix_data = hold_word[31:16];
            2'd2:    pix_data = hold_word[47:32];
            2'd3:    pix_data = hold_word[63:48];
            default: pix_data = hold_word[15:0];
        endcase
    end

endmodule

// File: tb/tb_fb_line_reader.sv
// Testbench for fb_line_reader: a randomized DDRAM responder and pixel
// consumer, checked against a framebuffer model computed from addresses.
module tb_fb_line_reader;

    localparam int WIDTH       = 1920;
    localparam int BURST       = 32;
    localparam int LINE_BURSTS = WIDTH / (4 * BURST);

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [10:0] line;
    logic        busy, done;
    logic        ddram_busy;
    logic [7:0]  ddram_burstcnt;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;
    logic [15:0] pix_data;
    logic        pix_valid, pix_ready, pix_last;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] exp_line = '0;
    int          bursts = 0;
    int          beats_left = 0;
    int          pix_idx = 0;
    int          done_cnt = 0;
    int          stall_left = 0;
    logic [28:0] cur_addr = '0, first_addr = '0, last_addr = '0, stall_addr = '0;
    bit          rand_busy = 0, rand_ready = 0, force_stall = 0, stall_req = 0;
    bit          rd_check_drop = 0, last_prev = 0, prev_stalled = 0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] seed_a = 32'h1234_5678, seed_b = 32'h9ABC_DEF0;

    always #5 clk = ~clk;

    fb_line_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .line             (line),
        .busy             (busy),
        .done             (done),
        .ddram_busy       (ddram_busy),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_addr       (ddram_addr),
        .ddram_rd         (ddram_rd),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_last         (pix_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Framebuffer contents as a function of the 64-bit word address.
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        logic [31:0] x;
        x = {3'b000, a};
        return {(x * 32'h9E37_79B1) ^ seed_a, x ^ seed_b};
    endfunction

    function automatic logic [15:0] ref_pixel(input logic [10:0] ln, input int idx);
        logic [31:0] baddr;
        logic [63:0] w;
        baddr = 32'h2000_0000 + 32'(ln) * 32'd4096 + 32'(idx / 4) * 32'd8;
        w = mem_word(baddr[31:3]);
        return w[(idx % 4) * 16 +: 16];
    endfunction

    function automatic logic [28:0] ref_burst_addr(input logic [10:0] ln, input int k);
        logic [31:0] baddr;
        baddr = 32'h2000_0000 + 32'(ln) * 32'd4096 + 32'(k) * 32'(BURST * 8);
        return baddr[31:3];
    endfunction

    // DDRAM responder: random stalls, one burst at a time, gapped beats.
    initial begin
        ddram_busy       = 1'b0;
        ddram_dout_ready = 1'b0;
        ddram_dout       = '0;
        forever begin
            @(negedge clk);
            ddram_dout_ready = 1'b0;
            if (beats_left > 0 && $urandom_range(0, 1) == 0) begin
                ddram_dout       = mem_word(cur_addr + 29'(BURST - beats_left));
                ddram_dout_ready = 1'b1;
                beats_left--;
            end
            if (rd_check_drop) begin
                rd_check_drop = 0;
                check("rd_drop_after_accept", ddram_rd, 1'b0);
            end
            if (stall_left > 0) begin
                check("stall_rd_held", ddram_rd, 1'b1);
                check("stall_addr_held", ddram_addr, stall_addr);
                stall_left--;
                ddram_busy = 1'b1;
            end else if (ddram_rd && stall_req) begin
                stall_req  = 0;
                stall_addr = ddram_addr;
                stall_left = 4;
                ddram_busy = 1'b1;
            end else begin
                ddram_busy = rand_busy && ($urandom_range(0, 3) == 0);
                if (ddram_rd && !ddram_busy) begin
                    check("burst_addr", ddram_addr, ref_burst_addr(exp_line, bursts));
                    check("single_outstanding", beats_left, 0);
                    if (bursts == 0) first_addr = ddram_addr;
                    last_addr     = ddram_addr;
                    cur_addr      = ddram_addr;
                    beats_left    = BURST;
                    bursts++;
                    rd_check_drop = 1;
                end
            end
        end
    end

    // Pixel consumer and stream monitor.
    initial begin
        pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (force_stall)     pix_ready = 1'b0;
            else if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
            else                 pix_ready = 1'b1;
            if (!reset_n) begin
                prev_stalled = 0;
                last_prev    = 0;
            end else begin
                if (prev_stalled) begin
                    check("hold_valid", pix_valid, 1'b1);
                    check("hold_data", pix_data, prev_data);
                    check("hold_last", pix_last, prev_last);
                end
                if (last_prev || done) check("done_timing", done, last_prev);
                if (done) begin
                    check("busy_low_at_done", busy, 1'b0);
                    done_cnt++;
                end
                last_prev    = 0;
                prev_stalled = 0;
                if (pix_valid && pix_ready) begin
                    check("pix_data", pix_data, ref_pixel(exp_line, pix_idx));
                    check("pix_last", pix_last, pix_idx == WIDTH - 1);
                    last_prev = (pix_idx == WIDTH - 1);
                    pix_idx++;
                end else if (pix_valid) begin
                    prev_stalled = 1;
                    prev_data    = pix_data;
                    prev_last    = pix_last;
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ddram_rd", ddram_rd, 1'b0);
        check("rst_ddram_addr", ddram_addr, 29'h0);
        check("rst_burstcnt", ddram_burstcnt, 8'd32);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_pix_data", pix_data, 16'h0);
        check("rst_pix_last", pix_last, 1'b0);
    endtask

    task automatic start_line(input logic [10:0] ln);
        @(negedge clk); #1;
        exp_line = ln;
        bursts   = 0;
        pix_idx  = 0;
        done_cnt = 0;
        line     = ln;
        req      = 1'b1;
        @(negedge clk); #1;
        req = 1'b0;
        check("busy_after_req", busy, 1'b1);
    endtask

    // One full line; optional consumer stall window and a stray req.
    task automatic run_line(input logic [10:0] ln, input bit bp, input bit extra);
        int cyc, b0, bp_cnt, bp_state;
        start_line(ln);
        cyc = 0; b0 = 0; bp_cnt = 0; bp_state = 0;
        while (done_cnt == 0 && cyc < 30000) begin
            if (extra && cyc == 100) begin
                req  = 1'b1;
                line = ln ^ 11'h2A5;
            end else begin
                req = 1'b0;
            end
            if (bp && bp_state == 0 && pix_idx >= 100) begin
                force_stall = 1;
                b0 = bursts;
                bp_state = 1;
            end else if (bp_state == 1) begin
                bp_cnt++;
                if (bp_cnt == 300) begin
                    check("bp_bursts_at_most_2", (bursts - b0) <= 2, 1'b1);
                    force_stall = 0;
                    bp_state = 2;
                end
            end
            @(negedge clk); #1;
            cyc++;
        end
        req = 1'b0;
        if (done_cnt == 0) check("done_timeout", 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        check("pixel_count", pix_idx, WIDTH);
        check("burst_count", bursts, LINE_BURSTS);
        check("done_pulses", done_cnt, 1);
        check("idle_after_line", busy, 1'b0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        req     = 1'b0;
        line    = '0;
        seed_a  = $urandom;
        seed_b  = $urandom;
        repeat (3) @(negedge clk);
        check_reset_values();
        #1 reset_n = 1'b1;

        // Basic read of line 0 at full consumer rate.
        rand_busy = 1;
        run_line(11'd0, 0, 0);
        check("first_addr_line0", first_addr, 29'h400_0000);
        check("last_addr_line0", last_addr, 29'h400_01C0);

        // Last visible line addressing.
        run_line(11'd1079, 0, 0);
        check("first_addr_line1079", first_addr, 29'h408_6E00);

        // Command stall of 5 cycles on the first burst.
        stall_req = 1;
        run_line(11'($urandom_range(0, 1079)), 0, 0);
        check("stall_exercised", stall_req, 1'b0);

        // Consumer backpressure for 300 cycles.
        rand_ready = 1;
        run_line(11'($urandom_range(0, 1079)), 1, 0);

        // Reset after 10 beats of the third burst, with stray beats following.
        start_line(11'd300);
        cyc = 0;
        while (!(bursts == 3 && beats_left == BURST - 10) && cyc < 20000) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("reached_burst3_beat10", bursts == 3 && beats_left == BURST - 10, 1'b1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        #1 reset_n = 1'b1;
        cyc = 0;
        while ((beats_left > 0 || cyc < 10) && cyc < 500) begin
            @(negedge clk); #1;
            cyc++;
            check("no_pix_after_reset", pix_valid, 1'b0);
            check("idle_after_reset", busy, 1'b0);
        end
        check("stray_beats_done", beats_left, 0);
        run_line(11'd5, 0, 0);

        // Request while busy must be ignored.
        run_line(11'($urandom_range(0, 1079)), 0, 1);

        // Random lines under random stalls on both sides.
        repeat (2) run_line(11'($urandom_range(0, 1079)), 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
